// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage: opcode constants,
// FSM state encoding and the decoded-bundle layout.
package instr_decode_stage_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned FUNCT_W = 2;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned DISP_W  = 11;
    localparam int unsigned REG_W   = 3;

    // Exact opcodes with special decode behaviour
    localparam logic [OPC_W-1:0] OP_HALT    = 5'b00000;
    localparam logic [OPC_W-1:0] OP_NWB_1   = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ILL_A   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ILL_B   = 5'b00011;
    localparam logic [OPC_W-1:0] OP_NWB_4   = 5'b00100;
    localparam logic [OPC_W-1:0] OP_NWB_5   = 5'b00101;
    localparam logic [OPC_W-1:0] OP_LINK_6  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_LINK_7  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_NWB_16  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_RT_17   = 5'b10001;
    localparam logic [OPC_W-1:0] OP_RS_18   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_RS_19   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_RS_24   = 5'b11000;
    localparam logic [OPC_W-1:0] OP_RT_25   = 5'b11001;
    localparam logic [OPC_W-1:0] OP_RD42_26 = 5'b11010;
    localparam logic [OPC_W-1:0] OP_RD42_27 = 5'b11011;

    // Opcode groups keyed on opcode[4:2]
    localparam logic [2:0] OPG_IMM5_A = 3'b010;
    localparam logic [2:0] OPG_NWB    = 3'b011;
    localparam logic [2:0] OPG_IMM5_B = 3'b100;
    localparam logic [2:0] OPG_IMM5_C = 3'b101;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [FUNCT_W-1:0] funct;
        logic [IMM_W-1:0]   imm;
        logic [DISP_W-1:0]  disp;
        logic [REG_W-1:0]   rs_sel;
        logic [REG_W-1:0]   rt_sel;
        logic [REG_W-1:0]   rd_sel;
        logic [PC_W-1:0]    pc;
        logic               reg_we;
        logic               halt;
        logic               err;
    } bundle_t;

endpackage

// File: rtl/instr_decode_stage_field_dec.sv
// Combinational field decoder: turns one instruction word plus its PC+2
// into a fully decoded bundle ready for storage.
module instr_field_dec
    import instr_decode_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output bundle_t            bundle_o
);

    logic [OPC_W-1:0] op;
    logic [2:0]       grp;
    logic             illegal;

    assign op      = instr_i[15:11];
    assign grp     = op[4:2];
    assign illegal = (op == OP_ILL_A) || (op == OP_ILL_B);

    always_comb begin
        bundle_o        = '0;
        bundle_o.opcode = op;
        bundle_o.funct  = instr_i[1:0];
        bundle_o.disp   = instr_i[10:0];
        bundle_o.rs_sel = instr_i[10:8];
        bundle_o.rt_sel = instr_i[7:5];
        bundle_o.pc     = pc_i;

        // Opcodes without a listed destination fall back to instr[4:2]
        if ((op == OP_RD42_26) || (op == OP_RD42_27))
            bundle_o.rd_sel = instr_i[4:2];
        else if ((grp == OPG_IMM5_A) || (grp == OPG_IMM5_C) ||
                 (op == OP_RT_17) || (op == OP_RT_25))
            bundle_o.rd_sel = instr_i[7:5];
        else if ((op == OP_RS_24) || (op == OP_RS_18) || (op == OP_RS_19))
            bundle_o.rd_sel = instr_i[10:8];
        else if ((op == OP_LINK_6) || (op == OP_LINK_7))
            bundle_o.rd_sel = 3'd7;
        else
            bundle_o.rd_sel = instr_i[4:2];

        if ((grp == OPG_IMM5_A) || (grp == OPG_IMM5_B) || (grp == OPG_IMM5_C))
            bundle_o.imm = {3'b000, instr_i[4:0]};
        else
            bundle_o.imm = instr_i[7:0];

        bundle_o.reg_we = ~((op == OP_HALT) || (op == OP_NWB_1) ||
                            (op == OP_NWB_4) || (op == OP_NWB_5) ||
                            (grp == OPG_NWB) || (op == OP_NWB_16) || illegal);
        bundle_o.halt   = (op == OP_HALT);
        bundle_o.err    = illegal;
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: valid/ready handshake, RUN/HALTED FSM and an
// output bundle register. Define DECODE_SKID_EN for a registered id_ready and a skid entry.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [PC_W-1:0]    if_pc,
    output logic               id_ready,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [OPC_W-1:0]   ex_opcode,
    output logic [FUNCT_W-1:0] ex_funct,
    output logic [IMM_W-1:0]   ex_imm,
    output logic [DISP_W-1:0]  ex_disp,
    output logic [REG_W-1:0]   ex_rs_sel,
    output logic [REG_W-1:0]   ex_rt_sel,
    output logic [REG_W-1:0]   ex_rd_sel,
    output logic [PC_W-1:0]    ex_pc,
    output logic               ex_reg_we,
    output logic               ex_halt,
    output logic               ex_err
);

    state_e  state_q, state_d;
    bundle_t dec_b;
    bundle_t ex_q, ex_d;
    logic    ex_valid_q, ex_valid_d;
    logic    out_free;
    logic    accept;

    instr_field_dec u_field_dec (
        .instr_i  (if_instr),
        .pc_i     (if_pc),
        .bundle_o (dec_b)
    );

    assign out_free = ~ex_valid_q | ex_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (accept && dec_b.halt) state_d = ST_HALTED;
            ST_HALTED: if (flush) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

`ifdef DECODE_SKID_EN
    bundle_t skid_q, skid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    ready_q, ready_d;

    assign id_ready = ready_q;
    // id_ready is a flop here, so flush has to gate acceptance internally
    assign accept   = if_valid & ready_q & ~flush;

    always_comb begin
        ex_d         = ex_q;
        ex_valid_d   = ex_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            ex_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                ex_d         = skid_q;
                ex_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                ex_d       = dec_b;
                ex_valid_d = 1'b1;
            end else begin
                ex_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_b;
            skid_valid_d = 1'b1;
        end
        ready_d = ~skid_valid_d & (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end
`else
    assign id_ready = rst_n & (state_q == ST_RUN) & out_free & ~flush;
    assign accept   = if_valid & id_ready;

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_d       = dec_b;
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_opcode = ex_q.opcode;
    assign ex_funct  = ex_q.funct;
    assign ex_imm    = ex_q.imm;
    assign ex_disp   = ex_q.disp;
    assign ex_rs_sel = ex_q.rs_sel;
    assign ex_rt_sel = ex_q.rt_sel;
    assign ex_rd_sel = ex_q.rd_sel;
    assign ex_pc     = ex_q.pc;
    assign ex_reg_we = ex_q.reg_we;
    assign ex_halt   = ex_q.halt;
    assign ex_err    = ex_q.err;

endmodule
